jtopl_mmr_q: RTL and testbench
==============================

# jtopl_mmr_q

Queued, multi-bank register front end for the JTOPL family. It accepts CPU address and data writes at full clk rate, applies timer and global registers immediately, and pushes operator and channel writes into a parametrised FIFO. Each queued write is presented to the register pipeline for one full slot rotation before the next one is released. It replaces the unqueued front end and adds bank (OPL3-style) selection and a busy handshake.

## Interface
- BANKS, 1: register banks; 1 or 2. With 1, addr[1] is ignored.
- DEPTH, 4: FIFO entries; power of 2, 2..16.
- SLOT_CYCLES, 18: cenop pulses each popped entry is held for.
- rst  in  1  synchronous active-high reset
- clk  in  1  system clock
- cenop  in  1  operator clock enable, from the divider
- din  in  8  CPU data
- write  in  1  CPU write strobe, one clk
- addr  in  2  [0]: 0=address, 1=data; [1]: bank
- busy  out  1  FIFO non-empty or hold active
- full  out  1  FIFO holds DEPTH entries
- ovf  out  1  sticky overflow flag (see Configuration)
- wr_data  out  8  data of the entry being held
- sel_bank  out  1  bank of the entry being held
- sel_group  out  2  group of the entry being held
- sel_sub  out  3  subslot of the entry being held
- up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnumlo, up_fnumhi, up_fbcon  out  1 each  update strobes, one-hot or all zero
- value_A, value_B  out  8  timer reload values
- load_A, load_B, flagen_A, flagen_B, clr_flag_A, clr_flag_B  out  1  timer control
- am_dep, vib_dep  out  1  global LFO depths (bank 0, reg BD)
- opl3_new  out  1  bank 1 reg 05 bit 0; forced 0 when BANKS=1

## Operation
- Address write (addr[0]=0): selreg[bank] <= din. One selreg per bank. Never queued.
- Data write (addr[0]=1), register r = selreg[addr[1]]:
  - Bank 0, r=02/03/04: value_A / value_B / timer bits updated on the same edge, exactly as the existing timer map: clr=din[7], flagen_A=~din[6], flagen_B=~din[5], {load_B,load_A}=din[1:0].
  - Bank 0, r=BD: am_dep=din[7], vib_dep=din[6].
  - Bank 1, r=05: opl3_new=din[0].
  - Operator registers (20..9F, r[2:0]<=5, r[4:3]!=3) and channel registers (A0..C8 with r[3:0]<=8, high nibble A/B/C) push {bank, r, din} into the FIFO.
  - All other registers are discarded.
- Decode at pop: group and subslot are derived identically to the existing map. Operator: group=r[4:3], sub=r[2:0]. Channel: group = r[3:0] /3 bucket, sub = r[3:0]<6 ? r[2:0] : {0, ~&r[2:1], r[0]}. The strobe is chosen by r[7:5] or r[7:4].
- Hold FSM with states IDLE and HOLD:
  - IDLE, FIFO non-empty, cenop=1: pop the entry, drive the outputs, load the counter with SLOT_CYCLES-1, go to HOLD.
  - HOLD: the counter decrements on each cenop. When it is 0 and cenop=1, go to IDLE, clear the strobes and leave wr_data/sel_* unchanged. An immediate pop is allowed on that same edge if the FIFO is non-empty (back-to-back).
- clr_flag_A/B auto-clear on a cenop cycle with no write, as before.

## Timing
- Reset values: all strobes 0, wr_data/sel_* 0, FIFO empty, busy=0, full=0, ovf=0, value_A/B=0, load_* 0, clr_* 0, flagen_A/B=1, am_dep=vib_dep=0, opl3_new=0, selreg=0, FSM IDLE.
- Push to visible strobe: next cenop edge, earliest 1 clk after the push when the FSM is IDLE.
- Strobe width: exactly SLOT_CYCLES cenop periods.
- busy rises on the edge after the push and falls on the edge that ends the last HOLD.
- Push and pop on the same edge: both happen; occupancy is unchanged. When full, the pop frees the slot first, so the push is accepted.
- Full without a pop: the data write is not queued (see Configuration). Immediate registers always apply.
- Pointers wrap modulo DEPTH. Occupancy is a separate counter of width log2(DEPTH)+1.
- Reset mid-HOLD clears the FSM and flushes the FIFO on that edge.

## Configuration
- JTOPL_MMR_OVF_EN defined: a queued write rejected while full sets ovf. ovf is cleared only by a bank-0 write to reg 04 with din[7]=1.
- JTOPL_MMR_OVF_EN undefined: rejected writes are dropped silently and ovf is tied to 0.

## Test plan
- Reset, then write addr 0x20, data 0x21 with cenop every 4 clk -> up_mult=1, sel_group=0, sel_sub=0, wr_data=0x21 for 18 cenops. busy is 1 throughout, then 0.
- Write A8=0x55 then B8=0x2A back-to-back -> up_fnumlo with sel_group=2, sel_sub=2 for 18 cenops, then up_fnumhi immediately on the next edge with no gap.
- With DEPTH=4 and cenop held low, make 5 queued writes -> full=1 after the 4th. The 5th is dropped, ovf=1 (OVF_EN). Writing reg 04 = 0x80 -> ovf=0, clr_flag_A=clr_flag_B=1.
- Write reg 02=0x7F and BD=0xC0 while the FIFO is full -> value_A=0x7F, am_dep=vib_dep=1 on the next edge. FIFO unchanged.
- BANKS=2: select bank 1 via addr=2'b10 with din=0x05, then write addr=2'b11 with din=0x01 -> opl3_new=1. Select bank 1 reg 0x40, write 0x3F -> sel_bank=1, up_ksl_tl=1.
- Assert rst for 1 clk mid-HOLD with 2 entries queued -> all outputs at reset values next edge, and no further strobes.

Source files
------------

// File: rtl/jtopl_mmr_q.sv
// jtopl_mmr_q: queued, multi-bank register front end for JTOPL.
//
// Timer and global registers are applied on the write edge. Operator and
// channel registers are queued in a FIFO. Each popped entry is held on the
// outputs for SLOT_CYCLES cenop periods before the next one is released.
//
// Optional build macro: JTOPL_MMR_OVF_EN enables the sticky overflow flag.
// When it is undefined, writes rejected by a full FIFO are dropped silently
// and o_ovf is tied low.
//
// Ports
//   i_rst, i_clk         synchronous active-high reset, system clock
//   i_cenop              operator clock enable
//   i_din, i_write       CPU data and one-clk write strobe
//   i_addr               [0]: 0=address, 1=data; [1]: bank (BANKS=2 only)
//   o_busy, o_full       FIFO non-empty or hold active; FIFO at DEPTH
//   o_ovf                sticky overflow flag
//   o_wr_data, o_sel_*   data/bank/group/subslot of the entry being held
//   o_up_*               one-hot update strobes (or all zero)
//   o_value_A/B, o_load_*, o_flagen_*, o_clr_flag_*   timer control
//   o_am_dep, o_vib_dep  global LFO depths
//   o_opl3_new           bank 1 reg 05 bit 0
//
// FSM
//   state | meaning
//   IDLE  | no entry presented, strobes low
//   HOLD  | entry presented, counting cenop pulses down to zero
module jtopl_mmr_q #(
    parameter int BANKS       = 1,
    parameter int DEPTH       = 4,
    parameter int SLOT_CYCLES = 18
) (
    input  logic       i_rst,
    input  logic       i_clk,
    input  logic       i_cenop,
    input  logic [7:0] i_din,
    input  logic       i_write,
    input  logic [1:0] i_addr,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_ovf,
    output logic [7:0] o_wr_data,
    output logic       o_sel_bank,
    output logic [1:0] o_sel_group,
    output logic [2:0] o_sel_sub,
    output logic       o_up_mult,
    output logic       o_up_ksl_tl,
    output logic       o_up_ar_dr,
    output logic       o_up_sl_rr,
    output logic       o_up_fnumlo,
    output logic       o_up_fnumhi,
    output logic       o_up_fbcon,
    output logic [7:0] o_value_A,
    output logic [7:0] o_value_B,
    output logic       o_load_A,
    output logic       o_load_B,
    output logic       o_flagen_A,
    output logic       o_flagen_B,
    output logic       o_clr_flag_A,
    output logic       o_clr_flag_B,
    output logic       o_am_dep,
    output logic       o_vib_dep,
    output logic       o_opl3_new
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SLOT_CYCLES) + 1;
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(SLOT_CYCLES - 1);

    typedef enum logic { IDLE = 1'b0, HOLD = 1'b1 } state_t;

    state_t        r_state;
    logic [CW-1:0] r_hold_cnt;
    logic [7:0]    r_selreg [2];
    logic [16:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [6:0]    r_strb;
    logic [7:0]    r_wr_data;
    logic          r_sel_bank;
    logic [1:0]    r_sel_group;
    logic [2:0]    r_sel_sub;
    logic [7:0]    r_value_A;
    logic [7:0]    r_value_B;
    logic          r_load_A, r_load_B;
    logic          r_flagen_A, r_flagen_B;
    logic          r_clr_flag_A, r_clr_flag_B;
    logic          r_am_dep, r_vib_dep;
    logic          r_opl3_new;

    logic          w_bank;
    logic [7:0]    w_reg;
    logic          w_addr_wr, w_data_wr;
    logic          w_is_op, w_is_ch, w_queue_req;
    logic          w_full, w_pop, w_push;
    logic [16:0]   w_head;
    logic [7:0]    w_hreg;
    logic [6:0]    w_hstrb;
    logic [1:0]    w_hgrp;
    logic [2:0]    w_hsub;

    // Single-bank builds ignore addr[1] entirely.
    assign w_bank    = (BANKS == 2) ? i_addr[1] : 1'b0;
    assign w_reg     = r_selreg[w_bank];
    assign w_addr_wr = i_write & ~i_addr[0];
    assign w_data_wr = i_write &  i_addr[0];

    assign w_is_op = (w_reg[7:5] >= 3'd1) && (w_reg[7:5] <= 3'd4) &&
                     (w_reg[2:0] <= 3'd5) && (w_reg[4:3] != 2'd3);
    assign w_is_ch = ((w_reg[7:4] == 4'hA) || (w_reg[7:4] == 4'hB) ||
                      (w_reg[7:4] == 4'hC)) && (w_reg[3:0] <= 4'd8);
    assign w_queue_req = w_data_wr & (w_is_op | w_is_ch);

    assign w_full = (r_count == FULL_CNT);
    // A pop happens on cenop from IDLE, or on the final cenop of a HOLD.
    assign w_pop  = i_cenop && (r_count != '0) &&
                    ((r_state == IDLE) || (r_hold_cnt == '0));
    // The pop frees a slot first, so a push on a full FIFO still lands.
    assign w_push = w_queue_req & (~w_full | w_pop);

    assign w_head = r_mem[r_rd_ptr];
    assign w_hreg = w_head[15:8];

    always_comb begin
        w_hstrb = '0;
        w_hgrp  = w_hreg[4:3];
        w_hsub  = w_hreg[2:0];
        case (w_hreg[7:4])
            4'hA, 4'hB, 4'hC: begin
                case (w_hreg[7:4])
                    4'hA:    w_hstrb = 7'b0000100;
                    4'hB:    w_hstrb = 7'b0000010;
                    default: w_hstrb = 7'b0000001;
                endcase
                // Channels 0-2 / 3-5 / 6-8 map to groups 0 / 1 / 2.
                if (w_hreg[3:0] < 4'd3)      w_hgrp = 2'd0;
                else if (w_hreg[3:0] < 4'd6) w_hgrp = 2'd1;
                else                         w_hgrp = 2'd2;
                if (w_hreg[3:0] >= 4'd6)
                    w_hsub = {1'b0, ~&w_hreg[2:1], w_hreg[0]};
            end
            default: begin
                case (w_hreg[7:5])
                    3'd1:    w_hstrb = 7'b1000000;
                    3'd2:    w_hstrb = 7'b0100000;
                    3'd3:    w_hstrb = 7'b0010000;
                    3'd4:    w_hstrb = 7'b0001000;
                    default: w_hstrb = 7'b0000000;
                endcase
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_bank, w_reg, i_din};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_strb      <= '0;
            r_wr_data   <= '0;
            r_sel_bank  <= 1'b0;
            r_sel_group <= '0;
            r_sel_sub   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state     <= HOLD;
                        r_hold_cnt  <= HOLD_LOAD;
                        r_strb      <= w_hstrb;
                        r_wr_data   <= w_head[7:0];
                        r_sel_bank  <= w_head[16];
                        r_sel_group <= w_hgrp;
                        r_sel_sub   <= w_hsub;
                    end
                end
                HOLD: begin
                    if (w_pop) begin
                        r_hold_cnt  <= HOLD_LOAD;
                        r_strb      <= w_hstrb;
                        r_wr_data   <= w_head[7:0];
                        r_sel_bank  <= w_head[16];
                        r_sel_group <= w_hgrp;
                        r_sel_sub   <= w_hsub;
                    end else if (i_cenop) begin
                        if (r_hold_cnt == '0) begin
                            r_state <= IDLE;
                            r_strb  <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_selreg[0]  <= '0;
            r_selreg[1]  <= '0;
            r_value_A    <= '0;
            r_value_B    <= '0;
            r_load_A     <= 1'b0;
            r_load_B     <= 1'b0;
            r_flagen_A   <= 1'b1;
            r_flagen_B   <= 1'b1;
            r_clr_flag_A <= 1'b0;
            r_clr_flag_B <= 1'b0;
            r_am_dep     <= 1'b0;
            r_vib_dep    <= 1'b0;
            r_opl3_new   <= 1'b0;
        end else begin
            if (i_cenop && !i_write) begin
                r_clr_flag_A <= 1'b0;
                r_clr_flag_B <= 1'b0;
            end
            if (w_addr_wr) r_selreg[w_bank] <= i_din;
            if (w_data_wr && !w_bank) begin
                case (w_reg)
                    8'h02: r_value_A <= i_din;
                    8'h03: r_value_B <= i_din;
                    8'h04: begin
                        r_clr_flag_A <= i_din[7];
                        r_clr_flag_B <= i_din[7];
                        r_flagen_A   <= ~i_din[6];
                        r_flagen_B   <= ~i_din[5];
                        {r_load_B, r_load_A} <= i_din[1:0];
                    end
                    8'hBD: begin
                        r_am_dep  <= i_din[7];
                        r_vib_dep <= i_din[6];
                    end
                    default: ;
                endcase
            end
            if (w_data_wr && w_bank && (w_reg == 8'h05)) r_opl3_new <= i_din[0];
        end
    end

`ifdef JTOPL_MMR_OVF_EN
    logic r_ovf;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_ovf <= 1'b0;
        else if (w_queue_req && w_full && !w_pop)
            r_ovf <= 1'b1;
        else if (w_data_wr && !w_bank && (w_reg == 8'h04) && i_din[7])
            r_ovf <= 1'b0;
    end
    assign o_ovf = r_ovf;
`else
    assign o_ovf = 1'b0;
`endif

    assign o_busy       = (r_count != '0) || (r_state == HOLD);
    assign o_full       = w_full;
    assign o_wr_data    = r_wr_data;
    assign o_sel_bank   = r_sel_bank;
    assign o_sel_group  = r_sel_group;
    assign o_sel_sub    = r_sel_sub;
    assign {o_up_mult, o_up_ksl_tl, o_up_ar_dr, o_up_sl_rr,
            o_up_fnumlo, o_up_fnumhi, o_up_fbcon} = r_strb;
    assign o_value_A    = r_value_A;
    assign o_value_B    = r_value_B;
    assign o_load_A     = r_load_A;
    assign o_load_B     = r_load_B;
    assign o_flagen_A   = r_flagen_A;
    assign o_flagen_B   = r_flagen_B;
    assign o_clr_flag_A = r_clr_flag_A;
    assign o_clr_flag_B = r_clr_flag_B;
    assign o_am_dep     = r_am_dep;
    assign o_vib_dep    = r_vib_dep;
    assign o_opl3_new   = (BANKS == 2) ? r_opl3_new : 1'b0;

endmodule

// File: tb/tb_jtopl_mmr_q.sv
module tb_jtopl_mmr_q;
    localparam int SLOT = 18;
`ifdef JTOPL_MMR_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cenop = 1'b0;
    logic [7:0] din = 8'h00;
    logic       write = 1'b0;
    logic [1:0] addr = 2'b00;

    logic       busy, full, ovf, sel_bank;
    logic [7:0] wr_data, value_A, value_B;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnumlo, up_fnumhi, up_fbcon;
    logic       load_A, load_B, flagen_A, flagen_B, clr_flag_A, clr_flag_B;
    logic       am_dep, vib_dep, opl3_new;

    jtopl_mmr_q #(.BANKS(2), .DEPTH(4), .SLOT_CYCLES(SLOT)) dut (
        .i_rst(rst), .i_clk(clk), .i_cenop(cenop), .i_din(din), .i_write(write),
        .i_addr(addr), .o_busy(busy), .o_full(full), .o_ovf(ovf),
        .o_wr_data(wr_data), .o_sel_bank(sel_bank), .o_sel_group(sel_group),
        .o_sel_sub(sel_sub), .o_up_mult(up_mult), .o_up_ksl_tl(up_ksl_tl),
        .o_up_ar_dr(up_ar_dr), .o_up_sl_rr(up_sl_rr), .o_up_fnumlo(up_fnumlo),
        .o_up_fnumhi(up_fnumhi), .o_up_fbcon(up_fbcon), .o_value_A(value_A),
        .o_value_B(value_B), .o_load_A(load_A), .o_load_B(load_B),
        .o_flagen_A(flagen_A), .o_flagen_B(flagen_B), .o_clr_flag_A(clr_flag_A),
        .o_clr_flag_B(clr_flag_B), .o_am_dep(am_dep), .o_vib_dep(vib_dep),
        .o_opl3_new(opl3_new)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [20:0] sb_q[$];
    bit          cen_en = 1'b0;

    wire [6:0] strb = {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnumlo, up_fnumhi, up_fbcon};

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {bank, group, sub, data, strobes} for a queued write.
    function automatic logic [20:0] exp_entry(input logic b, input logic [7:0] r, input logic [7:0] d);
        logic [6:0] s;
        logic [1:0] g;
        logic [2:0] sb;
        logic [3:0] lo;
        lo = r[3:0];
        g  = r[4:3];
        sb = r[2:0];
        case (r[7:4])
            4'h2, 4'h3: s = 7'b1000000;
            4'h4, 4'h5: s = 7'b0100000;
            4'h6, 4'h7: s = 7'b0010000;
            4'h8, 4'h9: s = 7'b0001000;
            4'hA:       s = 7'b0000100;
            4'hB:       s = 7'b0000010;
            4'hC:       s = 7'b0000001;
            default:    s = 7'b0000000;
        endcase
        if (r[7:4] >= 4'hA) begin
            g  = (lo < 4'd3) ? 2'd0 : (lo < 4'd6) ? 2'd1 : 2'd2;
            sb = (lo < 4'd6) ? r[2:0] : {1'b0, ~(r[2] & r[1]), r[0]};
        end
        return {b, g, sb, d, s};
    endfunction

    // cenop: one clk in every four while enabled.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            if (cen_en) begin
                div   = (div == 3) ? 0 : div + 1;
                cenop = (div == 3);
            end else begin
                div   = 0;
                cenop = 1'b0;
            end
        end
    end

    task automatic mon_start(input logic [20:0] act);
        chk_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) chk_eq("entry", 32'(act), 32'(sb_q.pop_front()));
        chk_eq("busy_hold", 32'(busy), 32'd1);
    endtask

    // Monitor: each presentation must last exactly SLOT cenops and match the
    // scoreboard head; strobes may only move on cenop edges.
    logic [6:0] mon_prev = '0;
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    always @(posedge clk) begin : mon
        logic c, r;
        c = cenop;
        r = rst;
        #1;
        if (r) begin
            mon_act = 1'b0;
            mon_cnt = 0;
        end else if (c) begin
            if (mon_act) begin
                mon_cnt++;
                if (mon_cnt == SLOT) begin
                    mon_cnt = 0;
                    if (strb != 0) begin
                        mon_start({sel_bank, sel_group, sel_sub, wr_data, strb});
                    end else begin
                        mon_act = 1'b0;
                        chk_eq("no_gap", 32'(sb_q.size()), 32'd0);
                    end
                end else begin
                    chk_eq("hold_width", 32'(strb), 32'(mon_prev));
                end
            end else if (strb != 0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                mon_start({sel_bank, sel_group, sel_sub, wr_data, strb});
            end
        end else begin
            chk_eq("strb_nocen", 32'(strb), 32'(mon_prev));
        end
        mon_prev = strb;
    end

    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        din   = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic q_wr(input logic b, input logic [7:0] r, input logic [7:0] d);
        cpu_wr({b, 1'b0}, r);
        cpu_wr({b, 1'b1}, d);
        sb_q.push_back(exp_entry(b, r, d));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk_eq({tag, "_idle"}, 32'(busy), 32'd0);
        chk_eq({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
        chk_eq({tag, "_full"}, 32'(full), 32'd0);
        chk_eq({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk_eq({tag, "_strb"}, 32'(strb), 32'd0);
        chk_eq({tag, "_sel"}, 32'({wr_data, sel_bank, sel_group, sel_sub}), 32'd0);
        chk_eq({tag, "_timer"}, 32'({value_A, value_B, load_A, load_B, clr_flag_A, clr_flag_B}), 32'd0);
        chk_eq({tag, "_flagen"}, 32'({flagen_A, flagen_B}), 32'd3);
        chk_eq({tag, "_glob"}, 32'({am_dep, vib_dep, opl3_new}), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("rst");

        cen_en = 1'b1;
        q_wr(1'b0, 8'h20, 8'h21);
        chk_eq("busy_rise", 32'(busy), 32'd1);
        drain("single");

        q_wr(1'b0, 8'hA8, 8'h55);
        q_wr(1'b0, 8'hB8, 8'h2A);
        drain("b2b");

        q_wr(1'b0, 8'hC8, 8'h0F);
        q_wr(1'b0, 8'hA3, 8'h33);
        q_wr(1'b0, 8'h95, 8'h44);
        drain("mix");

        cpu_wr(2'b00, 8'h26); cpu_wr(2'b01, 8'h01);
        cpu_wr(2'b00, 8'h38); cpu_wr(2'b01, 8'h02);
        cpu_wr(2'b00, 8'hC9); cpu_wr(2'b01, 8'h03);
        chk_eq("discard_busy", 32'(busy), 32'd0);

        cen_en = 1'b0;
        repeat (2) @(negedge clk);
        cpu_wr(2'b00, 8'h20);
        for (int i = 1; i <= 4; i++) begin
            cpu_wr(2'b01, 8'(i));
            sb_q.push_back(exp_entry(1'b0, 8'h20, 8'(i)));
        end
        chk_eq("full_4", 32'(full), 32'd1);
        chk_eq("ovf_pre", 32'(ovf), 32'd0);
        cpu_wr(2'b01, 8'h05);
        chk_eq("full_5", 32'(full), 32'd1);
        chk_eq("ovf_reject", 32'(ovf), 32'(OVF_EXP));

        cpu_wr(2'b00, 8'h02); cpu_wr(2'b01, 8'h7F);
        chk_eq("valA_full", 32'(value_A), 32'h7F);
        cpu_wr(2'b00, 8'hBD); cpu_wr(2'b01, 8'hC0);
        chk_eq("lfo_dep", 32'({am_dep, vib_dep}), 32'd3);
        chk_eq("full_kept", 32'(full), 32'd1);

        cpu_wr(2'b00, 8'h04); cpu_wr(2'b01, 8'h80);
        chk_eq("ovf_clr", 32'(ovf), 32'd0);
        chk_eq("clr_flags", 32'({clr_flag_A, clr_flag_B}), 32'd3);
        chk_eq("flagen_80", 32'({flagen_A, flagen_B, load_A, load_B}), 32'b1100);

        cen_en = 1'b1;
        repeat (8) @(negedge clk);
        chk_eq("clr_auto", 32'({clr_flag_A, clr_flag_B}), 32'd0);
        cpu_wr(2'b01, 8'h63);
        chk_eq("timer_63", 32'({flagen_A, flagen_B, load_A, load_B, clr_flag_A}), 32'b00110);
        cpu_wr(2'b00, 8'h03); cpu_wr(2'b01, 8'h9C);
        chk_eq("valB", 32'(value_B), 32'h9C);
        drain("full_drain");

        cpu_wr(2'b10, 8'h05); cpu_wr(2'b11, 8'h01);
        chk_eq("opl3_new", 32'(opl3_new), 32'd1);
        cpu_wr(2'b10, 8'h02); cpu_wr(2'b11, 8'h11);
        chk_eq("bank1_iso", 32'(value_A), 32'h7F);
        q_wr(1'b1, 8'h40, 8'h3F);
        drain("bank1");

        q_wr(1'b0, 8'h20, 8'hA1);
        q_wr(1'b0, 8'h21, 8'hA2);
        q_wr(1'b0, 8'h22, 8'hA3);
        n = 0;
        while (strb == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_eq("hold_seen", 32'(strb != 0), 32'd1);
        repeat (20) @(negedge clk);
        sb_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("midrst");
        repeat (300) @(negedge clk);
        chk_eq("post_rst_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
